// File: rtl/pump_mon_pkg.sv
// Shared types and constants for the pump command monitor.
package pump_mon_pkg;

    // Monitor supervisory state
    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        SUSPECT = 2'd1,
        ALARM   = 2'd2
    } mon_state_t;

    // Water level zone relative to the configured thresholds
    typedef enum logic [1:0] {
        LOW  = 2'd0,
        MID  = 2'd1,
        HIGH = 2'd2
    } zone_t;

    // Fault codes reported on fault_code
    localparam logic [1:0] FAULT_NONE = 2'b00;
    localparam logic [1:0] FAULT_DRY  = 2'b01;
    localparam logic [1:0] FAULT_OVF  = 2'b10;

endpackage

// File: rtl/pump_zone_classify.sv
// Combinational level-zone classifier and per-sample violation detect.
module pump_zone_classify
    import pump_mon_pkg::*;
#(
    parameter int LVL_W   = 8,
    parameter int LOW_TH  = 64,
    parameter int HIGH_TH = 192
) (
    input  logic [LVL_W-1:0] water_lvl,
    input  logic             pump1_ctrl,
    input  logic             pump2_ctrl,
    output zone_t            zone,
    output logic             dry,
    output logic             ovf
);

    localparam logic [LVL_W-1:0] LOW_V  = LVL_W'(LOW_TH);
    localparam logic [LVL_W-1:0] HIGH_V = LVL_W'(HIGH_TH);

    // Unsigned threshold compare into LOW / MID / HIGH
    always_comb begin
        zone = MID;
        if (water_lvl < LOW_V) begin
            zone = LOW;
        end else if (water_lvl >= HIGH_V) begin
            zone = HIGH;
        end
    end

    // Dry-run: low level with no pump filling; overflow: high level with any pump on
    always_comb begin
        dry = (zone == LOW)  && !pump1_ctrl && !pump2_ctrl;
        ovf = (zone == HIGH) && (pump1_ctrl || pump2_ctrl);
    end

endmodule

// File: rtl/pump_cmd_monitor.sv
// Pump command monitor: flags PLC pump commands inconsistent with the
// water level once they persist for GRACE_CYC samples, latches an alarm
// with a fault code and counts confirmed violations.
// Optional feature macro: PUMP_MON_OVERRIDE_EN (force safe pump drive in ALARM).
module pump_cmd_monitor
    import pump_mon_pkg::*;
#(
    parameter int LVL_W     = 8,
    parameter int LOW_TH    = 64,
    parameter int HIGH_TH   = 192,
    parameter int GRACE_CYC = 16,
    parameter int CNT_W     = 8
) (
    input  logic             CLK100MHZ,
    input  logic             rst_n,
    input  logic [LVL_W-1:0] water_lvl,
    input  logic             pump1_ctrl,
    input  logic             pump2_ctrl,
    input  logic             alarm_clr,
    output logic             alarm,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] violation_cnt,
    output logic             safe_pump1,
    output logic             safe_pump2
);

    localparam int GW = $clog2(GRACE_CYC) + 1;
    localparam logic [GW-1:0] GRACE_LAST = GW'(GRACE_CYC - 1);

    zone_t            zone;
    logic             dry;
    logic             ovf;
    logic             viol;

    mon_state_t       state_q, state_d;
    logic [GW-1:0]    grace_q, grace_d;
    logic [1:0]       fault_d;
    logic [CNT_W-1:0] cnt_d;
    logic             sp1_d, sp2_d;

    pump_zone_classify #(
        .LVL_W   (LVL_W),
        .LOW_TH  (LOW_TH),
        .HIGH_TH (HIGH_TH)
    ) u_zone (
        .water_lvl  (water_lvl),
        .pump1_ctrl (pump1_ctrl),
        .pump2_ctrl (pump2_ctrl),
        .zone       (zone),
        .dry        (dry),
        .ovf        (ovf)
    );

    // Violation for this sample; MID never counts
    always_comb begin
        viol = (zone != MID) && (dry || ovf);
    end

    // Next-state, grace window, fault latch, counter and pump drive
    always_comb begin
        state_d = state_q;
        grace_d = grace_q;
        fault_d = fault_code;
        cnt_d   = violation_cnt;
        sp1_d   = pump1_ctrl;
        sp2_d   = pump2_ctrl;

        case (state_q)
            NORMAL: begin
                if (viol) begin
                    state_d = SUSPECT;
                    grace_d = GW'(1);
                end
            end
            SUSPECT: begin
                if (!viol) begin
                    state_d = NORMAL;
                    grace_d = '0;
                end else if (grace_q == GRACE_LAST) begin
                    state_d = ALARM;
                    fault_d = dry ? FAULT_DRY : FAULT_OVF;
                    if (violation_cnt != '1) begin
                        cnt_d = violation_cnt + CNT_W'(1);
                    end
                end else begin
                    grace_d = grace_q + GW'(1);
                end
            end
            ALARM: begin
                if (alarm_clr && !viol) begin
                    state_d = NORMAL;
                    fault_d = FAULT_NONE;
                    grace_d = '0;
                end
            end
            default: begin
                state_d = NORMAL;
                grace_d = '0;
                fault_d = FAULT_NONE;
            end
        endcase

`ifdef PUMP_MON_OVERRIDE_EN
        // Keyed on the next state so the force tracks alarm edge for edge
        if (state_d == ALARM) begin
            sp1_d = (fault_d == FAULT_DRY);
            sp2_d = 1'b0;
        end
`endif
    end

    // State and output registers
    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= NORMAL;
            grace_q       <= '0;
            alarm         <= 1'b0;
            fault_code    <= FAULT_NONE;
            violation_cnt <= '0;
            safe_pump1    <= 1'b0;
            safe_pump2    <= 1'b0;
        end else begin
            state_q       <= state_d;
            grace_q       <= grace_d;
            alarm         <= (state_d == ALARM);
            fault_code    <= fault_d;
            violation_cnt <= cnt_d;
            safe_pump1    <= sp1_d;
            safe_pump2    <= sp2_d;
        end
    end

endmodule

// File: tb/tb_pump_cmd_monitor.sv
// Self-checking bench for pump_cmd_monitor (follows PUMP_MON_OVERRIDE_EN).
module tb_pump_cmd_monitor;

`ifdef PUMP_MON_OVERRIDE_EN
    localparam bit OVR = 1'b1;
`else
    localparam bit OVR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] water_lvl;
    logic       pump1_ctrl, pump2_ctrl, alarm_clr;

    logic       alarm_a, sp1_a, sp2_a;
    logic [1:0] fault_a;
    logic [7:0] cnt_a;
    logic       alarm_b, sp1_b, sp2_b;
    logic [1:0] fault_b;
    logic [1:0] cnt_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pump_cmd_monitor dut (
        .CLK100MHZ(clk), .rst_n(rst_n), .water_lvl(water_lvl),
        .pump1_ctrl(pump1_ctrl), .pump2_ctrl(pump2_ctrl), .alarm_clr(alarm_clr),
        .alarm(alarm_a), .fault_code(fault_a), .violation_cnt(cnt_a),
        .safe_pump1(sp1_a), .safe_pump2(sp2_a)
    );

    pump_cmd_monitor #(.CNT_W(2)) dut2 (
        .CLK100MHZ(clk), .rst_n(rst_n), .water_lvl(water_lvl),
        .pump1_ctrl(pump1_ctrl), .pump2_ctrl(pump2_ctrl), .alarm_clr(alarm_clr),
        .alarm(alarm_b), .fault_code(fault_b), .violation_cnt(cnt_b),
        .safe_pump1(sp1_b), .safe_pump2(sp2_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: run length of consecutive violating samples
    int         run;
    bit         m_alarm;
    logic [1:0] m_fault;
    int         m_cnt8, m_cnt2;
    logic       m_sp1, m_sp2;
    bit         s_dry, s_ovf, s_v;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run = 0; m_alarm = 0; m_fault = 2'b00;
            m_cnt8 = 0; m_cnt2 = 0; m_sp1 = 0; m_sp2 = 0;
        end else begin
            s_dry = (water_lvl < 64) && !pump1_ctrl && !pump2_ctrl;
            s_ovf = (water_lvl >= 192) && (pump1_ctrl || pump2_ctrl);
            s_v   = s_dry || s_ovf;
            if (!m_alarm) begin
                run = s_v ? run + 1 : 0;
                if (run == 16) begin
                    m_alarm = 1;
                    m_fault = s_dry ? 2'b01 : 2'b10;
                    if (m_cnt8 < 255) m_cnt8++;
                    if (m_cnt2 < 3) m_cnt2++;
                end
            end else if (alarm_clr && !s_v) begin
                m_alarm = 0; m_fault = 2'b00; run = 0;
            end
            if (OVR && m_alarm) begin
                m_sp1 = (m_fault == 2'b01); m_sp2 = 0;
            end else begin
                m_sp1 = pump1_ctrl; m_sp2 = pump2_ctrl;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("alarm",     {31'd0, alarm_a}, {31'd0, m_alarm});
        chk("fault",     {30'd0, fault_a}, {30'd0, m_fault});
        chk("cnt8",      {24'd0, cnt_a},   m_cnt8);
        chk("safe1",     {31'd0, sp1_a},   {31'd0, m_sp1});
        chk("safe2",     {31'd0, sp2_a},   {31'd0, m_sp2});
        chk("cnt2",      {30'd0, cnt_b},   m_cnt2);
        chk("alarm_w2",  {31'd0, alarm_b}, {31'd0, m_alarm});
        chk("fault_w2",  {30'd0, fault_b}, {30'd0, m_fault});
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_all_reset(input string tag);
        chk({tag, "_alarm"}, {31'd0, alarm_a}, 0);
        chk({tag, "_fault"}, {30'd0, fault_a}, 0);
        chk({tag, "_cnt"},   {24'd0, cnt_a},   0);
        chk({tag, "_sp1"},   {31'd0, sp1_a},   0);
        chk({tag, "_sp2"},   {31'd0, sp2_a},   0);
        chk({tag, "_cnt2"},  {30'd0, cnt_b},   0);
    endtask

    int exp_c2 [5];

    initial begin
        exp_c2 = '{1, 2, 3, 3, 3};
        rst_n = 0; water_lvl = 8'd100; pump1_ctrl = 0; pump2_ctrl = 0; alarm_clr = 0;
        cycles(3);
        chk_all_reset("rst");
        rst_n = 1;

        // MID level, pump1 on: never a violation, safe_pump1 follows
        pump1_ctrl = 1;
        @(negedge clk);
        chk("mid_sp1_latency", {31'd0, sp1_a}, 1);
        cycles(49);
        chk("mid_alarm", {31'd0, alarm_a}, 0);
        chk("mid_fault", {30'd0, fault_a}, 0);

        // Dry run held: alarm after edge 16
        water_lvl = 8'd30; pump1_ctrl = 0;
        cycles(15);
        chk("dry_e15_alarm", {31'd0, alarm_a}, 0);
        @(negedge clk);
        chk("dry_e16_alarm", {31'd0, alarm_a}, 1);
        chk("dry_fault",     {30'd0, fault_a}, 1);
        chk("dry_cnt",       {24'd0, cnt_a},   1);
        chk("dry_sp1",       {31'd0, sp1_a},   {31'd0, OVR});
        chk("dry_sp2",       {31'd0, sp2_a},   0);
        water_lvl = 8'd100; alarm_clr = 1;
        @(negedge clk);
        alarm_clr = 0;
        chk("dry_clr_alarm", {31'd0, alarm_a}, 0);
        chk("dry_clr_fault", {30'd0, fault_a}, 0);

        // Overflow: 15 bad, 1 clean, 16 bad
        water_lvl = 8'd200; pump2_ctrl = 1;
        cycles(15);
        chk("ovf_burst1", {31'd0, alarm_a}, 0);
        pump2_ctrl = 0;
        @(negedge clk);
        pump2_ctrl = 1;
        cycles(15);
        chk("ovf_b2_e15", {31'd0, alarm_a}, 0);
        @(negedge clk);
        chk("ovf_b2_e16", {31'd0, alarm_a}, 1);
        chk("ovf_fault",  {30'd0, fault_a}, 2);
        chk("ovf_cnt",    {24'd0, cnt_a},   2);
        chk("ovf_sp2",    {31'd0, sp2_a},   {31'd0, !OVR});

        // Clear ignored while violating, then honoured
        alarm_clr = 1;
        @(negedge clk);
        alarm_clr = 0;
        chk("clr_ignored", {31'd0, alarm_a}, 1);
        pump2_ctrl = 0; alarm_clr = 1;
        @(negedge clk);
        alarm_clr = 0;
        chk("clr_ok_alarm", {31'd0, alarm_a}, 0);
        chk("clr_ok_fault", {30'd0, fault_a}, 0);

        // Saturation: fresh start, five alarm/clear rounds
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            water_lvl = 8'd30;
            cycles(16);
            chk("sat_alarm", {31'd0, alarm_b}, 1);
            chk("sat_cnt2",  {30'd0, cnt_b},   exp_c2[i]);
            chk("sat_cnt8",  {24'd0, cnt_a},   i + 1);
            water_lvl = 8'd100; alarm_clr = 1;
            @(negedge clk);
            alarm_clr = 0;
        end

        // Reset mid-window at grace 10
        water_lvl = 8'd200; pump1_ctrl = 1;
        cycles(10);
        chk("win_sp1", {31'd0, sp1_a}, 1);
        #2 rst_n = 0;
        #1 chk_all_reset("rst_win");
        @(negedge clk);
        rst_n = 1;
        cycles(15);
        chk("restart_e15", {31'd0, alarm_a}, 0);
        @(negedge clk);
        chk("restart_e16", {31'd0, alarm_a}, 1);
        chk("restart_cnt", {24'd0, cnt_a},   1);

        // Reset during ALARM
        #2 rst_n = 0;
        #1 chk_all_reset("rst_alm");
        @(negedge clk);
        rst_n = 1;
        pump1_ctrl = 0; water_lvl = 8'd100;
        cycles(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
